// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bus constants for the I2C responder
// Purpose: one place for the responder FSM state type and the ACK/NACK bit levels.
// Ports: none (package).
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_filter.sv
// rtl/i2c_line_filter.sv - synchronizer, agreement filter and edge pulses for one bus line
// Purpose: bring an asynchronous I2C line into the clock domain and reject short glitches.
// Ports:
//   clock - system clock
//   reset - synchronous active-high reset (filter presets to idle-high)
//   line  - raw bus pin
//   filt  - filtered line level
//   rise  - one-cycle pulse in the first cycle filt is high
//   fall  - one-cycle pulse in the first cycle filt is low
module i2c_line_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic line,
  output logic filt,
  output logic rise,
  output logic fall
);

  logic [1:0]          sync;
  logic [FILT_LEN-2:0] hist;
  logic [FILT_LEN-1:0] window;
  logic                agree_hi;
  logic                agree_lo;

  // The newest synchronized sample plus the previous FILT_LEN-1 samples must
  // all agree before the filtered level moves; this gives 2 + FILT_LEN cycles
  // from a pin change to the filtered edge.
  assign window   = {hist, sync[1]};
  assign agree_hi = &window;
  assign agree_lo = ~(|window);

  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= '1;
      hist <= '1;
      filt <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], line};
      hist <= window[FILT_LEN-2:0];
      rise <= agree_hi & ~filt;
      fall <= agree_lo & filt;
      if (agree_hi) begin
        filt <= 1'b1;
      end else if (agree_lo) begin
        filt <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/i2c_slave_responder.sv
// rtl/i2c_slave_responder.sv - I2C target turning bus writes into register strobes and serving reads
// Purpose: decode START/STOP and address/register/data bytes from an oversampled
//          I2C bus, pulse a register-write strobe per data byte, and shift out
//          register contents for reads.
// Ports:
//   clock    - system clock
//   reset    - synchronous active-high reset
//   i2c_sclk - bus clock input (never stretched)
//   i2c_sdat - open-drain bus data, driven 0 or z
//   wr_en    - one-cycle register-write strobe
//   wr_addr  - register address for wr_en
//   wr_data  - register data for wr_en
//   rd_addr  - register pointer presented for reads
//   rd_data  - register contents at rd_addr (combinational from user)
//   busy     - high from an address-matched ACK until STOP or a mismatch
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h39,
  parameter int         FILT_LEN   = 3,
  parameter int         SDA_HOLD   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       i2c_sclk,
  inout  wire        i2c_sdat,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam int HW = $clog2(SDA_HOLD + 1);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;
  logic start_ev, stop_ev;

  state_t     state, state_n;
  logic [3:0] bit_cnt, bit_n;
  logic [7:0] shreg, sh_n, byte_in;
  logic [7:0] ptr_n, wr_addr_n, wr_data_n;
  logic       rw, rw_n, wr_en_n, busy_n;

  // Drive requests raised at an SCL fall and applied SDA_HOLD cycles later.
  logic          sched, sched_low, release_now;
  logic [HW-1:0] hold_cnt;
  logic          pend_low, drive_low;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clock(clock), .reset(reset), .line(i2c_sclk),
    .filt(scl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clock(clock), .reset(reset), .line(i2c_sdat),
    .filt(sda), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_ev = sda_fall & scl;
  assign stop_ev  = sda_rise & scl;
  assign byte_in  = {shreg[6:0], sda};
  assign i2c_sdat = drive_low ? 1'b0 : 1'bz;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      rd_addr <= '0;
      rw      <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_n;
      shreg   <= sh_n;
      rd_addr <= ptr_n;
      rw      <= rw_n;
      wr_en   <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      busy    <= busy_n;
    end
  end

  // In the ACK states bit_cnt is 0 until the ninth SCL rise and 1 after it,
  // which tells the fall that starts the ACK apart from the fall that ends it.
  always_comb begin
    state_n     = state;
    bit_n       = bit_cnt;
    sh_n        = shreg;
    ptr_n       = rd_addr;
    rw_n        = rw;
    wr_en_n     = 1'b0;
    wr_addr_n   = wr_addr;
    wr_data_n   = wr_data;
    busy_n      = busy;
    sched       = 1'b0;
    sched_low   = 1'b0;
    release_now = 1'b0;
    if (stop_ev) begin
      state_n     = ST_IDLE;
      bit_n       = '0;
      busy_n      = 1'b0;
      release_now = 1'b1;
    end else if (start_ev) begin
      state_n     = ST_ADDR;
      bit_n       = '0;
      release_now = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE, ST_WAIT_STOP: begin
        end
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise) begin
            sh_n  = byte_in;
            bit_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_n = '0;
              if (state == ST_ADDR) begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  state_n = ST_ADDR_ACK;
                  rw_n    = byte_in[0];
                  busy_n  = 1'b1;
                end else begin
                  state_n = ST_WAIT_STOP;
                  busy_n  = 1'b0;
                end
              end else if (state == ST_REG) begin
                ptr_n   = byte_in;
                state_n = ST_REG_ACK;
              end else begin
                wr_en_n   = 1'b1;
                wr_addr_n = rd_addr;
                wr_data_n = byte_in;
                ptr_n     = rd_addr + 8'd1;
                state_n   = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
          if (scl_rise) begin
            bit_n = 4'd1;
          end else if (scl_fall) begin
            sched = 1'b1;
            if (bit_cnt == 4'd0) begin
              sched_low = ~I2C_ACK;
            end else begin
              bit_n = '0;
              if (state == ST_ADDR_ACK && rw) begin
                sh_n      = rd_data;
                sched_low = ~rd_data[7];
                state_n   = ST_RDATA;
              end else begin
                state_n = (state == ST_ADDR_ACK) ? ST_REG : ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bit_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_n   = '0;
              state_n = ST_RDATA_ACK;
            end
          end else if (scl_fall) begin
            sh_n      = {shreg[6:0], shreg[7]};
            sched     = 1'b1;
            sched_low = ~shreg[6];
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (sda == I2C_NACK) begin
              state_n = ST_WAIT_STOP;
              bit_n   = '0;
            end else begin
              bit_n = 4'd1;
              ptr_n = rd_addr + 8'd1;
            end
          end else if (scl_fall) begin
            sched = 1'b1;
            if (bit_cnt != 4'd0) begin
              // Pointer moved at the ACK rise, so rd_data is settled by now.
              sh_n      = rd_data;
              sched_low = ~rd_data[7];
              bit_n     = '0;
              state_n   = ST_RDATA;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      drive_low <= 1'b0;
      hold_cnt  <= '0;
      pend_low  <= 1'b0;
    end else if (release_now) begin
      drive_low <= 1'b0;
      hold_cnt  <= '0;
    end else if (sched) begin
      hold_cnt <= HW'(SDA_HOLD);
      pend_low <= sched_low;
    end else if (hold_cnt != '0) begin
      hold_cnt <= hold_cnt - HW'(1);
      if (hold_cnt == HW'(1)) begin
        drive_low <= pend_low;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb/tb_i2c_slave_responder.sv - self-checking bench for the I2C responder
module tb_i2c_slave_responder;

  localparam int Q = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  wire        sda_bus;
  logic       wr_en, busy;
  logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
  logic [7:0] rom [256];

  int checks = 0;
  int errors = 0;

  logic [15:0] wr_q  [$];
  logic [15:0] exp_q [$];
  int          wr_double = 0;
  logic        wr_en_prev = 1'b0;
  logic        slave_drove = 1'b0;

  typedef struct {
    logic [7:0]      addr_byte;
    logic [7:0]      reg_a;
    int              n;
    logic [2:0][7:0] d;
    logic            exp_nack;
    logic [7:0]      exp_ptr;
  } vec_t;

  always #5 clock = ~clock;

  pullup (sda_bus);
  assign sda_bus = sda_m ? 1'bz : 1'b0;
  assign rd_data = rom[rd_addr];

  i2c_slave_responder #(.SLAVE_ADDR(7'h39), .FILT_LEN(3), .SDA_HOLD(4)) dut (
    .clock(clock), .reset(reset), .i2c_sclk(scl_m), .i2c_sdat(sda_bus),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
  );

  always @(negedge clock) begin
    if (wr_en) wr_q.push_back({wr_addr, wr_data});
    if (wr_en && wr_en_prev) wr_double++;
    wr_en_prev = wr_en;
    if (sda_m && !sda_bus) slave_drove = 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic bit_xfer(input logic b, input int glitch, output logic r);
    sda_m = b;
    wait_cyc(Q);
    scl_m = 1'b1;
    wait_cyc(Q / 2);
    if (glitch == 1 && b) begin
      sda_m = 1'b0; wait_cyc(1); sda_m = 1'b1;
    end
    if (glitch == 2) begin
      scl_m = 1'b0; wait_cyc(2); scl_m = 1'b1;
    end
    wait_cyc(Q / 2);
    r = sda_bus;
    wait_cyc(Q);
    scl_m = 1'b0;
    wait_cyc(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b0; wait_cyc(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_cyc(Q);
    scl_m = 1'b1; wait_cyc(Q);
    sda_m = 1'b1; wait_cyc(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic [7:0] sda_gl,
                           input logic [7:0] scl_gl, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], sda_gl[i] ? 1 : (scl_gl[i] ? 2 : 0), r);
    bit_xfer(1'b1, 0, ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 0, r);
      b[i] = r;
    end
    bit_xfer(nack, 0, r);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count"}, wr_q.size(), exp_q.size());
    while (exp_q.size() > 0 && wr_q.size() > 0)
      check({tag, "_wr"}, wr_q.pop_front(), exp_q.pop_front());
    wr_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vec_t       vt [5];
    logic       ack;
    logic [7:0] ptr_m;
    logic [7:0] b8, rd, rg, dd;
    logic [6:0] a7;
    int         kind, n;

    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h08] = 8'h5C;
    rom[8'h09] = 8'hA6;

    vt[0] = '{8'h72, 8'h15, 1, {8'h00, 8'h00, 8'hA5}, 1'b0, 8'h16};
    vt[1] = '{8'h70, 8'h15, 1, {8'h00, 8'h00, 8'hA5}, 1'b1, 8'h16};
    vt[2] = '{8'h72, 8'hFF, 2, {8'h00, 8'h22, 8'h11}, 1'b0, 8'h01};
    vt[3] = '{8'h74, 8'h44, 1, {8'h00, 8'h00, 8'h99}, 1'b1, 8'h01};
    vt[4] = '{8'h72, 8'h7E, 3, {8'h03, 8'h02, 8'h01}, 1'b0, 8'h81};

    wait_cyc(3);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_sda", sda_bus, 1);
    reset = 1'b0;
    wait_cyc(5);
    ptr_m = 8'h00;

    for (int v = 0; v < 5; v++) begin
      slave_drove = 1'b0;
      wr_q.delete();
      i2c_start();
      send_byte(vt[v].addr_byte, 8'h00, 8'h00, ack);
      check($sformatf("vec%0d_addr_ack", v), ack, vt[v].exp_nack);
      check($sformatf("vec%0d_busy", v), busy, !vt[v].exp_nack);
      send_byte(vt[v].reg_a, 8'h00, 8'h00, ack);
      check($sformatf("vec%0d_reg_ack", v), ack, vt[v].exp_nack);
      for (int i = 0; i < vt[v].n; i++) begin
        send_byte(vt[v].d[i], 8'h00, 8'h00, ack);
        check($sformatf("vec%0d_data%0d_ack", v, i), ack, vt[v].exp_nack);
        if (!vt[v].exp_nack) exp_q.push_back({vt[v].reg_a + 8'(i), vt[v].d[i]});
      end
      i2c_stop();
      if (!vt[v].exp_nack) ptr_m = vt[v].reg_a + 8'(vt[v].n);
      check($sformatf("vec%0d_busy_after_stop", v), busy, 0);
      check($sformatf("vec%0d_sda_driven", v), slave_drove, !vt[v].exp_nack);
      check($sformatf("vec%0d_rd_addr", v), rd_addr, vt[v].exp_ptr);
      check_writes($sformatf("vec%0d", v));
    end

    // Set pointer, repeated start, read two bytes (ACK then NACK).
    i2c_start();
    send_byte(8'h72, 8'h00, 8'h00, ack);
    send_byte(8'h08, 8'h00, 8'h00, ack);
    check("rd_reg_ack", ack, 0);
    i2c_start();
    send_byte(8'h73, 8'h00, 8'h00, ack);
    check("rd_addr_ack", ack, 0);
    recv_byte(1'b0, rd);
    check("rd_byte0", rd, 8'h5C);
    recv_byte(1'b1, rd);
    check("rd_byte1", rd, 8'hA6);
    wait_cyc(Q);
    check("rd_sda_released", sda_bus, 1);
    check("rd_ptr", rd_addr, 8'h09);
    i2c_stop();
    check("rd_busy_after_stop", busy, 0);
    check_writes("rd_seq");
    ptr_m = 8'h09;

    // SDA glitch while SCL high and SCL glitch mid-byte must be invisible.
    i2c_start();
    send_byte(8'h72, 8'h00, 8'h00, ack);
    send_byte(8'h30, 8'h00, 8'h00, ack);
    send_byte(8'hC3, 8'b1000_0001, 8'b0010_0000, ack);
    check("glitch_data_ack", ack, 0);
    i2c_stop();
    exp_q.push_back(16'h30C3);
    check_writes("glitch");
    ptr_m = 8'h31;

    // Reset in the middle of a data byte, then a clean transaction.
    i2c_start();
    send_byte(8'h72, 8'h00, 8'h00, ack);
    send_byte(8'h15, 8'h00, 8'h00, ack);
    b8 = 8'hA5;
    for (int i = 7; i >= 4; i--) bit_xfer(b8[i], 0, ack);
    sda_m = 1'b1;
    reset = 1'b1;
    wait_cyc(2);
    check("midrst_sda", sda_bus, 1);
    reset = 1'b0;
    wait_cyc(1);
    check("midrst_rd_addr", rd_addr, 0);
    check("midrst_busy", busy, 0);
    check_writes("midrst");
    i2c_start();
    send_byte(8'h72, 8'h00, 8'h00, ack);
    check("postrst_addr_ack", ack, 0);
    send_byte(8'h20, 8'h00, 8'h00, ack);
    send_byte(8'h5A, 8'h00, 8'h00, ack);
    i2c_stop();
    exp_q.push_back(16'h205A);
    check_writes("postrst");
    check("postrst_rd_addr", rd_addr, 8'h21);
    ptr_m = 8'h21;

    // Randomized transactions against the pointer/ROM model.
    for (int t = 0; t < 8; t++) begin
      kind = $urandom_range(0, 2);
      n = $urandom_range(1, 3);
      i2c_start();
      if (kind == 0) begin
        rg = 8'($urandom);
        send_byte(8'h72, 8'h00, 8'h00, ack);
        check($sformatf("rnd%0d_w_addr_ack", t), ack, 0);
        send_byte(rg, 8'h00, 8'h00, ack);
        ptr_m = rg;
        for (int i = 0; i < n; i++) begin
          dd = 8'($urandom);
          send_byte(dd, 8'h00, 8'h00, ack);
          exp_q.push_back({ptr_m, dd});
          ptr_m = ptr_m + 8'd1;
        end
      end else if (kind == 1) begin
        send_byte(8'h73, 8'h00, 8'h00, ack);
        check($sformatf("rnd%0d_r_addr_ack", t), ack, 0);
        for (int i = 0; i < n; i++) begin
          recv_byte(i == n - 1, rd);
          check($sformatf("rnd%0d_r_byte%0d", t, i), rd, rom[ptr_m]);
          if (i != n - 1) ptr_m = ptr_m + 8'd1;
        end
      end else begin
        do a7 = 7'($urandom_range(0, 127)); while (a7 == 7'h39);
        send_byte({a7, 1'($urandom)}, 8'h00, 8'h00, ack);
        check($sformatf("rnd%0d_bad_addr_nack", t), ack, 1);
        send_byte(8'($urandom), 8'h00, 8'h00, ack);
      end
      i2c_stop();
      check($sformatf("rnd%0d_rd_addr", t), rd_addr, ptr_m);
      check($sformatf("rnd%0d_busy", t), busy, 0);
      check_writes($sformatf("rnd%0d", t));
    end

    check("wr_en_single_cycle", wr_double, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
# i2c_slave_responder

I2C target (responder) for the configuration bus: the receiving end of the 3-byte write transactions (slave address, register, data) our I2C master issues. It also serves register reads. It oversamples SCL/SDA on the system clock and decodes START/STOP. Writes go to a simple register-write strobe interface and reads come from a combinational register-read port, so on-chip blocks can sit on the same I2C bus as external devices.

## Interface
- SLAVE_ADDR, 7'h39: 7-bit address matched in the first byte (8-bit form 0x72/0x73).
- FILT_LEN, 3: consecutive equal samples required before a filtered line changes.
- SDA_HOLD, 4: CLOCK cycles between detected SCL fall and the SDA drive change.
- CLOCK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- I2C_SCLK  in  1  bus clock; this block never stretches it.
- I2C_SDAT  inout  1  open-drain data; driven 0 or z only.
- WR_EN  out  1  one-cycle register-write strobe.
- WR_ADDR  out  8  register address for WR_EN.
- WR_DATA  out  8  register data for WR_EN.
- RD_ADDR  out  8  register pointer presented for reads.
- RD_DATA  in  8  register contents at RD_ADDR, combinational from the user.
- BUSY  out  1  high from an address-matched ACK until STOP or a mismatch.

## Operation
- Line path per signal:
  - 2-flop synchronizer, then a FILT_LEN-sample agreement filter.
  - Edges are detected on the filtered values only.
- Bus events:
  - START: filtered SDA falls while filtered SCL is high.
  - STOP: filtered SDA rises while filtered SCL is high.
  - Data bits are sampled on filtered SCL rise, MSB first.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- IDLE → ADDR on START.
- ADDR, after 8 bits:
  - Address match → ADDR_ACK; SDA is pulled low for the 9th clock.
  - Mismatch → WAIT_STOP; SDA is never driven.
- ADDR_ACK exit:
  - R/W=0 → REG.
  - R/W=1 → RDATA; RD_DATA is loaded into the shift register at the ACK-clock SCL fall.
- REG: 8 bits load the pointer (RD_ADDR), then REG_ACK (ACK driven) → WDATA.
- WDATA: on the 8th bit sample:
  - WR_EN pulses for 1 cycle with WR_ADDR = pointer, WR_DATA = byte.
  - Then WDATA_ACK (ACK driven); the pointer increments.
  - Back to WDATA for the next burst byte.
- RDATA: drive shift-register bits; SDA changes only SDA_HOLD cycles after an SCL fall. Then RDATA_ACK samples the master's bit:
  - ACK (0): pointer increments; reload from RD_DATA at the SCL fall; back to RDATA.
  - NACK (1): release SDA and go to WAIT_STOP.
- Pointer arithmetic is 8-bit modulo; 0xFF increments to 0x00.
- START in any state (repeated start) → ADDR and release SDA; the pointer is kept.
- STOP in any state → IDLE and release SDA; a partial byte is discarded with no WR_EN.
- START and STOP detection take priority over bit sampling in the same cycle.

## Timing
- Reset values:
  - WR_EN=0, WR_ADDR=0, WR_DATA=0, RD_ADDR=0, BUSY=0.
  - SDA released (z), state IDLE, filters preset to 1.
- Reset mid-transfer: the next cycle is IDLE with SDA released. The block then waits for a fresh START.
- Input latency: 2 + FILT_LEN cycles from a pin change to the filtered edge.
- WR_EN asserts 1 cycle after the 8th data-bit SCL rise is detected.
- RD_DATA must be valid 1 cycle after RD_ADDR changes.
- ACK drive: SDA goes low SDA_HOLD cycles after the SCL fall ending bit 8, and is released SDA_HOLD cycles after the SCL fall ending bit 9.
- Requirement: the SCL low phase must exceed 2+FILT_LEN+SDA_HOLD+1 cycles. At the default values that is 10 cycles.

## Structure
- Shared package i2c_pkg holds:
  - the state enum;
  - the constants I2C_ACK=1'b0 and I2C_NACK=1'b1.
- Sub-module i2c_line_filter (synchronizer plus agreement filter plus rise/fall pulses) is instantiated twice, once for SCL and once for SDA.
- The top level holds the FSM, bit counter, shift register, pointer and open-drain assignment.

## Test plan
- Write 0x72, 0x15, 0xA5, STOP → three ACKs; exactly one WR_EN with WR_ADDR=0x15, WR_DATA=0xA5; BUSY clears after STOP.
- Write 0x70, … → NACK on the address, no WR_EN, SDA never driven, BUSY stays 0.
- Burst 0x72, 0xFF, 0x11, 0x22 → WR_EN pulses (0xFF,0x11) then (0x00,0x22); final RD_ADDR=0x01.
- Write 0x72, 0x08, then Sr, 0x73; read two bytes with master ACK then NACK, then STOP:
  - Required: RD_DATA for 0x08 then for 0x09 on SDA, MSB first.
  - Required: slave releases SDA after the NACK.
- Single-cycle SDA glitch while SCL is high, plus a 2-cycle SCL glitch → no START/STOP detected, state unchanged.
- RESET asserted mid-way through the 0xA5 data byte → no WR_EN, SDA released; the next full transaction 0x72, 0x20, 0x5A writes correctly.
